// File: rtl/mpu_frame_assembler.sv
// mpu_frame_assembler: paces MPU6050 burst reads and packs the 14-byte burst
//   (0x3B..0x48) into seven signed 16-bit words, presented atomically.
// Latency: frame_valid and the new words appear one cycle after the 14th byte
//   is sampled. Request pulse fires one cycle after pending && !busy_now.
// Backpressure: none downstream. Requests are held off while busy_now is high.
//   A period that elapses with a request still pending sets the sticky overrun.
//
// Ports:
//   clk, rst             - single clock, synchronous active-high reset
//   init_done            - sensor configured; pacing runs only while high
//   busy_now             - I2C engine busy; defers the request pulse
//   data_avalid, data    - one-cycle byte strobe and byte from the reader
//   mpu_transfer         - one-cycle burst-read request
//   accel_*/temp_raw/gyro_* - packed big-endian sensor words (bit-exact)
//   frame_valid          - one-cycle strobe, all seven words just updated
//   frame_err            - one-cycle strobe, frame aborted on byte timeout
//   overrun              - sticky: period wrapped while a request was pending

module mpu_frame_assembler #(
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 20000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_done,
  input  logic        busy_now,
  input  logic        data_avalid,
  input  logic [7:0]  data,
  output logic        mpu_transfer,
  output logic [15:0] accel_x,
  output logic [15:0] accel_y,
  output logic [15:0] accel_z,
  output logic [15:0] temp_raw,
  output logic [15:0] gyro_x,
  output logic [15:0] gyro_y,
  output logic [15:0] gyro_z,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        overrun
);

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_COLLECT,
    S_DONE
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   per_cnt_q, per_cnt_d;
  logic [TW-1:0]   to_cnt_q;
  logic [3:0]      idx_q;
  logic            pending_q, pending_d;
  logic            overrun_q, overrun_d;
  logic            xfer_q, fvalid_q, ferr_q;
  logic [15:0]     accel_x_q, accel_y_q, accel_z_q, temp_q;
  logic [15:0]     gyro_x_q, gyro_y_q, gyro_z_q;
  logic [7:0]      shadow_q [0:13];
  logic            wrap;

  // Period pacing runs in every state except IDLE.
  assign wrap = (state_q != S_IDLE) && (per_cnt_q == PW'(PERIOD - 1));

  always_comb begin
    per_cnt_d = per_cnt_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (state_q == S_IDLE) begin
      per_cnt_d = '0;
      pending_d = 1'b0;
    end else begin
      per_cnt_d = wrap ? '0 : per_cnt_q + 1'b1;
      if (state_q == S_REQ) pending_d = 1'b0;
      // A wrap landing on REQ re-arms pending; the old request is being
      // served that very cycle, so it is not an overrun.
      if (wrap) begin
        pending_d = 1'b1;
        if (pending_q && state_q != S_REQ) overrun_d = 1'b1;
      end
    end
  end

  // Shadow bytes need no reset: the index restarts at 0 for every frame and
  // the outputs only load after all 14 positions have been rewritten.
  always_ff @(posedge clk) begin
    if (state_q == S_COLLECT && data_avalid) shadow_q[idx_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      per_cnt_q <= '0;
      to_cnt_q  <= '0;
      idx_q     <= '0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      xfer_q    <= 1'b0;
      fvalid_q  <= 1'b0;
      ferr_q    <= 1'b0;
      accel_x_q <= '0;
      accel_y_q <= '0;
      accel_z_q <= '0;
      temp_q    <= '0;
      gyro_x_q  <= '0;
      gyro_y_q  <= '0;
      gyro_z_q  <= '0;
    end else begin
      xfer_q   <= 1'b0;
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      if (!init_done) begin
        // Sensor lost: drop everything silently, no strobes.
        state_q   <= S_IDLE;
        per_cnt_q <= '0;
        pending_q <= 1'b0;
        to_cnt_q  <= '0;
        idx_q     <= '0;
      end else begin
        per_cnt_q <= per_cnt_d;
        pending_q <= pending_d;
        overrun_q <= overrun_d;
        case (state_q)
          S_IDLE: state_q <= S_WAIT;
          S_WAIT: begin
            if (pending_q && !busy_now) begin
              state_q <= S_REQ;
              xfer_q  <= 1'b1;
            end
          end
          S_REQ: begin
            idx_q    <= '0;
            to_cnt_q <= '0;
            state_q  <= S_COLLECT;
          end
          S_COLLECT: begin
            if (data_avalid) begin
              to_cnt_q <= '0;
              if (idx_q == 4'd13) begin
                // Last byte goes straight into gyro_z so the words and
                // frame_valid appear together one cycle after it.
                accel_x_q <= {shadow_q[0],  shadow_q[1]};
                accel_y_q <= {shadow_q[2],  shadow_q[3]};
                accel_z_q <= {shadow_q[4],  shadow_q[5]};
                temp_q    <= {shadow_q[6],  shadow_q[7]};
                gyro_x_q  <= {shadow_q[8],  shadow_q[9]};
                gyro_y_q  <= {shadow_q[10], shadow_q[11]};
                gyro_z_q  <= {shadow_q[12], data};
                fvalid_q  <= 1'b1;
                idx_q     <= '0;
                state_q   <= S_DONE;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end else if (to_cnt_q == TW'(TIMEOUT - 2)) begin
              // Counter is about to reach TIMEOUT-1: abort the frame.
              ferr_q   <= 1'b1;
              idx_q    <= '0;
              to_cnt_q <= '0;
              state_q  <= S_WAIT;
            end else begin
              to_cnt_q <= to_cnt_q + 1'b1;
            end
          end
          S_DONE:  state_q <= S_WAIT;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mpu_transfer = xfer_q;
  assign frame_valid  = fvalid_q;
  assign frame_err    = ferr_q;
  assign overrun      = overrun_q;
  assign accel_x      = accel_x_q;
  assign accel_y      = accel_y_q;
  assign accel_z      = accel_z_q;
  assign temp_raw     = temp_q;
  assign gyro_x       = gyro_x_q;
  assign gyro_y       = gyro_y_q;
  assign gyro_z       = gyro_z_q;

endmodule

// File: tb/tb_mpu_frame_assembler.sv
// tb_mpu_frame_assembler: randomized scoreboard bench for mpu_frame_assembler.
// Expected strobes (request, frame, timeout) are predicted from the sample
// period / timeout rules and queued; a negedge monitor pops and compares them.

module tb_mpu_frame_assembler;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 40;

  localparam logic [1:0] EV_XFER  = 2'd0;
  localparam logic [1:0] EV_VALID = 2'd1;
  localparam logic [1:0] EV_ERR   = 2'd2;

  typedef struct packed {
    logic [1:0]   kind;
    logic [31:0]  cyc;
    logic [111:0] w;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst, init_done, busy_now, data_avalid;
  logic [7:0]  data;
  logic        mpu_transfer, frame_valid, frame_err, overrun;
  logic [15:0] accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  ev_t         exp_q[$];
  logic [111:0] model_words = '0;
  logic [7:0]  fb [14];
  int          pos [14];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mpu_frame_assembler #(.PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .busy_now(busy_now),
    .data_avalid(data_avalid), .data(data), .mpu_transfer(mpu_transfer),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .temp_raw(temp_raw), .gyro_x(gyro_x), .gyro_y(gyro_y), .gyro_z(gyro_z),
    .frame_valid(frame_valid), .frame_err(frame_err), .overrun(overrun)
  );

  function automatic logic [111:0] dut_words();
    return {accel_x, accel_y, accel_z, temp_raw, gyro_x, gyro_y, gyro_z};
  endfunction

  // Reference packing: word k = byte[2k]*256 + byte[2k+1], accel_x first.
  function automatic logic [111:0] model_pack();
    logic [111:0] r = '0;
    for (int k = 0; k < 7; k++) begin
      int v;
      v = int'(fb[2*k]) * 256 + int'(fb[2*k+1]);
      r[111-16*k -: 16] = v[15:0];
    end
    return r;
  endfunction

  function automatic string kname(input logic [1:0] k);
    case (k)
      EV_XFER:  return "mpu_transfer";
      EV_VALID: return "frame_valid";
      default:  return "frame_err";
    endcase
  endfunction

  function automatic void push_ev(input logic [1:0] k, input int c, input logic [111:0] w);
    ev_t e;
    e.kind = k;
    e.cyc  = 32'(c);
    e.w    = w;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic see(input logic [1:0] kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_%s: seen at cycle %0d, none expected", kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== kind || e.cyc !== 32'(cyc)) begin
        errors++;
        $display("FAIL event: got %s at cycle %0d expected %s at cycle %0d",
                 kname(kind), cyc, kname(e.kind), e.cyc);
      end else if (kind == EV_VALID) begin
        chk("frame_words", dut_words(), e.w);
      end
    end
  endtask

  // Monitor: every strobe must match the next predicted event.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mpu_transfer) see(EV_XFER);
      if (frame_valid)  see(EV_VALID);
      if (frame_err)    see(EV_ERR);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int n);
    while (cyc < n) step();
  endtask

  task automatic rand_bytes();
    for (int j = 0; j < 14; j++) fb[j] = 8'($urandom_range(255, 0));
  endtask

  task automatic make_pos(input int start, input int gmin, input int gmax);
    pos[0] = start;
    for (int j = 1; j < 14; j++) pos[j] = pos[j-1] + int'($urandom_range(gmax, gmin));
  endtask

  task automatic send(input int from, input int to);
    for (int j = from; j <= to; j++) begin
      goto(pos[j]);
      data_avalid = 1'b1;
      data        = fb[j];
      step();
      data_avalid = 1'b0;
    end
  endtask

  initial begin
    int w, t, r, w2, v;
    rst = 1'b1; init_done = 1'b0; busy_now = 1'b0; data_avalid = 1'b0; data = '0;
    repeat (3) step();
    chk("rst_words", dut_words(), '0);
    chk("rst_strobes", {mpu_transfer, frame_valid, frame_err, overrun}, '0);
    rst = 1'b0;
    repeat (3) step();
    chk("idle_strobes", {mpu_transfer, frame_valid, frame_err, overrun}, '0);

    init_done = 1'b1;
    w = cyc + 1;  // first WAIT cycle, period counter 0

    // Request with no reply: times out TIMEOUT cycles after the request.
    t = w + PERIOD + 1;
    push_ev(EV_XFER, t, '0);
    push_ev(EV_ERR, t + TIMEOUT, '0);
    goto(t + TIMEOUT + 1);
    chk("words_before_first_frame", dut_words(), model_words);

    // Bytes 01..0E, one every 3 cycles.
    t = w + 2 * PERIOD + 1;
    push_ev(EV_XFER, t, '0);
    for (int j = 0; j < 14; j++) fb[j] = 8'(j + 1);
    make_pos(t + 2, 3, 3);
    push_ev(EV_VALID, pos[13] + 1, model_pack());
    send(0, 13);
    goto(pos[13] + 2);
    model_words = model_pack();
    chk("words_seq", dut_words(), model_words);

    // Negative accel_x, random rest, random gaps; then stray strobes in WAIT.
    t = w + 3 * PERIOD + 1;
    push_ev(EV_XFER, t, '0);
    rand_bytes();
    fb[0] = 8'hFF;
    fb[1] = 8'h38;
    make_pos(t + 1 + int'($urandom_range(4, 0)), 1, 5);
    push_ev(EV_VALID, pos[13] + 1, model_pack());
    send(0, 13);
    goto(pos[13] + 2);
    model_words = model_pack();
    chk("words_neg", dut_words(), model_words);
    chk_int("accel_x_signed", int'($signed(accel_x)), -200);
    v = pos[13] + 1;
    for (int s = 3; s <= 12; s += 3) begin
      goto(v + s);
      data_avalid = 1'b1;
      data        = 8'($urandom_range(255, 0));
      step();
      data_avalid = 1'b0;
    end
    goto(v + 15);
    chk("words_after_strays", dut_words(), model_words);

    // Five bytes then silence: timeout, outputs untouched.
    t = w + 4 * PERIOD + 1;
    push_ev(EV_XFER, t, '0);
    rand_bytes();
    make_pos(t + 1 + int'($urandom_range(4, 0)), 1, 5);
    push_ev(EV_ERR, pos[4] + TIMEOUT, '0);
    send(0, 4);
    goto(pos[4] + TIMEOUT + 2);
    chk("words_after_timeout", dut_words(), model_words);

    // Next request restarts at index 0.
    t = w + 5 * PERIOD + 1;
    push_ev(EV_XFER, t, '0);
    rand_bytes();
    make_pos(t + 1 + int'($urandom_range(4, 0)), 1, 5);
    push_ev(EV_VALID, pos[13] + 1, model_pack());
    send(0, 13);
    goto(pos[13] + 2);
    model_words = model_pack();
    chk("words_after_restart", dut_words(), model_words);

    // Busy for 250 cycles spanning two wraps: overrun, one deferred request.
    goto(w + 590);
    busy_now = 1'b1;
    t = w + 841;
    push_ev(EV_XFER, t, '0);
    goto(w + 690);
    chk("overrun_before_second_wrap", overrun, 1'b0);
    goto(w + 705);
    chk("overrun_set", overrun, 1'b1);
    goto(w + 840);
    busy_now = 1'b0;
    rand_bytes();
    make_pos(t + 1, 1, 4);
    push_ev(EV_VALID, pos[13] + 1, model_pack());
    send(0, 13);
    goto(pos[13] + 2);
    model_words = model_pack();
    chk("words_after_busy", dut_words(), model_words);
    chk("overrun_sticky", overrun, 1'b1);

    // Reset after 7 bytes: everything clears, remaining bytes are ignored.
    t = w + 9 * PERIOD + 1;
    push_ev(EV_XFER, t, '0);
    rand_bytes();
    make_pos(t + 1, 1, 3);
    send(0, 6);
    r = pos[6] + 2;
    goto(r);
    rst = 1'b1;
    step();
    step();
    chk("words_after_rst", dut_words(), '0);
    chk("strobes_after_rst", {mpu_transfer, frame_valid, frame_err, overrun}, '0);
    rst = 1'b0;
    model_words = '0;
    w2 = r + 3;
    push_ev(EV_XFER, w2 + PERIOD + 1, '0);
    push_ev(EV_ERR, w2 + PERIOD + 1 + TIMEOUT, '0);
    for (int j = 7; j < 14; j++) pos[j] = w2 + 2 * (j - 7);
    send(7, 13);
    goto(w2 + 20);
    chk("words_after_orphan_bytes", dut_words(), model_words);
    goto(w2 + PERIOD + TIMEOUT + 10);
    chk_int("events_outstanding", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
